// File: rtl/cdc_pkg.sv
// cdc_pkg: shared definitions for the req/ack CDC handshake receiver.
//   cdc_hs_state_e      - receive FSM state encoding
//   CDC_SYNC_STAGES_MIN - smallest legal req synchroniser depth
package cdc_pkg;

  localparam int unsigned CDC_SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    CDC_HS_IDLE     = 2'd0,
    CDC_HS_WAIT_ACC = 2'd1,
    CDC_HS_ACK_HI   = 2'd2
  } cdc_hs_state_e;

endpackage

// File: rtl/cdc_sync_n.sv
// cdc_sync_n: N-flop level synchroniser with asynchronous active-low reset to 0.
// Ports:
//   clk   in  destination-domain clock
//   rst_n in  asynchronous active-low reset
//   i_d   in  foreign-domain level
//   o_q   out synchronised level (last flop of the chain)
module cdc_sync_n
  import cdc_pkg::*;
#(
  parameter int unsigned N = CDC_SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < N; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: receive side of a 4-phase req/ack handshake bringing a DW-bit word
// into the clk domain. req_async is synchronised; data_async is captured only on
// the capture edge (sender holds it stable while req is high).
// Ports:
//   clk, rst_n  receive clock, asynchronous active-low reset
//   req_async   sender request (foreign domain)
//   data_async  sender data, stable while req_async = 1
//   ack         acknowledge to sender, flop-driven
//   o_valid     o_data holds an unconsumed word
//   o_data      captured word
//   i_ready     consumer accept (pop when o_valid & i_ready)
//   proto_err   sticky: req dropped before the word was accepted
// Build option CDC_HS_RX_SKID_EN: ack decoupled from the consumer through a
// one-entry buffer; proto_err tied low.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_async,
  input  logic [DW-1:0] data_async,
  output logic          ack,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
  output logic          proto_err
);

  if (SYNC_STAGES < CDC_SYNC_STAGES_MIN) begin : g_sync_stages_chk
    $error("cdc_hs_rx: SYNC_STAGES must be >= %0d", CDC_SYNC_STAGES_MIN);
  end

  cdc_hs_state_e r_state, w_state_nx;
  logic          r_ack, w_ack_nx;
  logic          r_valid, w_valid_nx;
  logic          r_perr, w_perr_nx;
  logic [DW-1:0] r_data;
  logic          w_req_s;
  logic          w_capture;
  logic          w_pop;

  cdc_sync_n #(.N(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (req_async),
    .o_q   (w_req_s)
  );

  assign w_pop = r_valid & i_ready;

  always_comb begin
    w_state_nx = r_state;
    w_ack_nx   = r_ack;
    w_valid_nx = r_valid;
    w_perr_nx  = r_perr;
    w_capture  = 1'b0;
`ifdef CDC_HS_RX_SKID_EN
    // One-entry buffer: a pop empties it unless a capture refills it on the same edge.
    w_perr_nx = 1'b0;
    if (w_pop) begin
      w_valid_nx = 1'b0;
    end
    unique case (r_state)
      CDC_HS_IDLE: begin
        if (w_req_s && (!r_valid || i_ready)) begin
          w_capture  = 1'b1;
          w_valid_nx = 1'b1;
          w_ack_nx   = 1'b1;
          w_state_nx = CDC_HS_ACK_HI;
        end
      end
      CDC_HS_ACK_HI: begin
        if (!w_req_s) begin
          w_ack_nx   = 1'b0;
          w_state_nx = CDC_HS_IDLE;
        end
      end
      default: begin
        w_ack_nx   = 1'b0;
        w_state_nx = CDC_HS_IDLE;
      end
    endcase
`else
    unique case (r_state)
      CDC_HS_IDLE: begin
        if (w_req_s) begin
          w_capture  = 1'b1;
          w_valid_nx = 1'b1;
          w_state_nx = CDC_HS_WAIT_ACC;
        end
      end
      CDC_HS_WAIT_ACC: begin
        // A req drop here is flagged, but the held word is still delivered.
        if (!w_req_s) begin
          w_perr_nx = 1'b1;
        end
        if (w_pop) begin
          w_valid_nx = 1'b0;
          w_ack_nx   = 1'b1;
          w_state_nx = CDC_HS_ACK_HI;
        end
      end
      CDC_HS_ACK_HI: begin
        if (!w_req_s) begin
          w_ack_nx   = 1'b0;
          w_state_nx = CDC_HS_IDLE;
        end
      end
      default: begin
        w_ack_nx   = 1'b0;
        w_state_nx = CDC_HS_IDLE;
      end
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CDC_HS_IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ack   <= w_ack_nx;
      r_valid <= w_valid_nx;
      r_perr  <= w_perr_nx;
      if (w_capture) begin
        r_data <= data_async;
      end
    end
  end

  assign ack       = r_ack;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign proto_err = r_perr;

endmodule

// File: tb/tb_cdc_hs_rx.sv
`timescale 1ns/1ps
module tb_cdc_hs_rx;

  localparam int unsigned DW = 32;

`ifdef CDC_HS_RX_SKID_EN
  localparam logic EXP_ACK_ON_CAPTURE = 1'b1;
  localparam logic EXP_PERR_ON_DROP   = 1'b0;
`else
  localparam logic EXP_ACK_ON_CAPTURE = 1'b0;
  localparam logic EXP_PERR_ON_DROP   = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          sclk = 1'b0;
  logic          rst_n;
  logic          req_async;
  logic [DW-1:0] data_async;
  logic          ack;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic          proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5    clk  = ~clk;   // 100 MHz receive clock
  always #13.5 sclk = ~sclk;  // ~37 MHz sender clock

  cdc_hs_rx #(.DW(DW), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .proto_err  (proto_err)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned rdy_dly;
    bit          early_drop;
    logic        exp_perr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    req_async  = 1'b0;
    i_ready    = 1'b0;
    data_async = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int unsigned budget);
    int unsigned k = 0;
    while (!o_valid && k < budget) begin
      tick;
      k++;
    end
    chk(name, 64'(o_valid), 64'd1);
  endtask

  task automatic wait_ack(input string name, input logic lvl, input int unsigned budget);
    int unsigned k = 0;
    while (ack !== lvl && k < budget) begin
      tick;
      k++;
    end
    chk(name, 64'(ack), 64'(lvl));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    do_reset;
    data_async = v.data;
    req_async  = 1'b1;
    wait_valid($sformatf("vec%0d_valid", idx), 8);
    chk($sformatf("vec%0d_data", idx), 64'(o_data), 64'(v.exp_data));
    if (v.early_drop) begin
      req_async = 1'b0;
      repeat (3) tick;
    end
    repeat (v.rdy_dly) tick;
    chk($sformatf("vec%0d_held", idx), 64'(o_valid), 64'd1);
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    chk($sformatf("vec%0d_popped", idx), 64'(o_valid), 64'd0);
    chk($sformatf("vec%0d_perr", idx), 64'(proto_err), 64'(v.exp_perr));
    req_async = 1'b0;
    wait_ack($sformatf("vec%0d_ack_low", idx), 1'b0, 10);
    repeat (3) tick;
    chk($sformatf("vec%0d_once", idx), 64'(o_valid), 64'd0);
    chk($sformatf("vec%0d_perr_sticky", idx), 64'(proto_err), 64'(v.exp_perr));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_q[$];
    int unsigned got;

    rst_n      = 1'b0;
    req_async  = 1'b0;
    i_ready    = 1'b0;
    data_async = '0;

    vt[0] = '{32'hA5A5_0001, 0, 1'b0, 1'b0, 32'hA5A5_0001};
    vt[1] = '{32'h0000_0000, 3, 1'b0, 1'b0, 32'h0000_0000};
    vt[2] = '{32'hFFFF_FFFF, 5, 1'b1, EXP_PERR_ON_DROP, 32'hFFFF_FFFF};
    vt[3] = '{32'h8000_0001, 1, 1'b1, EXP_PERR_ON_DROP, 32'h8000_0001};

    // Reset state
    do_reset;
    chk("rst_ack",   64'(ack),       64'd0);
    chk("rst_valid", 64'(o_valid),   64'd0);
    chk("rst_data",  64'(o_data),    64'd0);
    chk("rst_perr",  64'(proto_err), 64'd0);

    // Single transfer with cycle-exact latency
    i_ready    = 1'b1;
    data_async = 32'hDEAD_BEEF;
    req_async  = 1'b1;
    tick; chk("t1_e0_valid", 64'(o_valid), 64'd0);
    tick; chk("t1_e1_valid", 64'(o_valid), 64'd0);
    tick; chk("t1_e2_valid", 64'(o_valid), 64'd1);
    chk("t1_e2_data", 64'(o_data), 64'hDEAD_BEEF);
    chk("t1_e2_ack",  64'(ack), 64'(EXP_ACK_ON_CAPTURE));
    tick; chk("t1_acc_valid", 64'(o_valid), 64'd0);
    chk("t1_acc_ack", 64'(ack), 64'd1);
    req_async = 1'b0;
    tick;
    tick; chk("t1_d1_ack", 64'(ack), 64'd1);
    tick; chk("t1_d2_ack", 64'(ack), 64'd0);
    chk("t1_data_hold", 64'(o_data), 64'hDEAD_BEEF);

    // Backpressure
    do_reset;
    data_async = 32'h1234_5678;
    req_async  = 1'b1;
    repeat (3) tick;
    chk("t2_valid", 64'(o_valid), 64'd1);
    chk("t2_data",  64'(o_data),  64'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk($sformatf("t2_bp%0d_valid", i), 64'(o_valid), 64'd1);
      chk($sformatf("t2_bp%0d_ack", i),   64'(ack), 64'(EXP_ACK_ON_CAPTURE));
    end
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    chk("t2_pop_valid", 64'(o_valid), 64'd0);
    chk("t2_pop_ack",   64'(ack), 64'd1);
    req_async = 1'b0;
    repeat (3) tick;
    chk("t2_ack_low", 64'(ack), 64'd0);

    // Table of single transfers, including req dropped before acceptance
    for (int i = 0; i < 4; i++) run_vec(i, vt[i]);

    // Reset asserted while in ACK_HI, req held across release
    data_async = 32'hCAFE_0005;
    i_ready    = 1'b1;
    req_async  = 1'b1;
    repeat (4) tick;
    chk("t5_pre_ack",   64'(ack),     64'd1);
    chk("t5_pre_valid", 64'(o_valid), 64'd0);
    i_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ack",   64'(ack),       64'd0);
    chk("t5_async_valid", 64'(o_valid),   64'd0);
    chk("t5_async_perr",  64'(proto_err), 64'd0);
    chk("t5_async_data",  64'(o_data),    64'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick; tick;
    chk("t5_e1_valid", 64'(o_valid), 64'd0);
    tick;
    chk("t5_recap_valid", 64'(o_valid), 64'd1);
    chk("t5_recap_data",  64'(o_data),  64'hCAFE_0005);
    i_ready = 1'b1;
    tick;
    chk("t5_pop", 64'(o_valid), 64'd0);
    repeat (3) tick;
    chk("t5_once", 64'(o_valid), 64'd0);
    i_ready   = 1'b0;
    req_async = 1'b0;
    wait_ack("t5_ack_low", 1'b0, 10);

`ifdef CDC_HS_RX_SKID_EN
    // Second request while the first word is still unconsumed
    do_reset;
    data_async = 32'hAAAA_0001;
    req_async  = 1'b1;
    repeat (3) tick;
    chk("t6_a_valid", 64'(o_valid), 64'd1);
    chk("t6_a_ack",   64'(ack), 64'd1);
    req_async = 1'b0;
    repeat (3) tick;
    chk("t6_a_ack_low", 64'(ack), 64'd0);
    data_async = 32'hBBBB_0002;
    req_async  = 1'b1;
    repeat (5) tick;
    chk("t6_b_stall_ack",  64'(ack),     64'd0);
    chk("t6_b_stall_data", 64'(o_data),  64'hAAAA_0001);
    chk("t6_b_stall_vld",  64'(o_valid), 64'd1);
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    chk("t6_b_cap_vld",  64'(o_valid), 64'd1);
    chk("t6_b_cap_data", 64'(o_data),  64'hBBBB_0002);
    chk("t6_b_cap_ack",  64'(ack), 64'd1);
    req_async = 1'b0;
    wait_ack("t6_b_ack_low", 1'b0, 10);
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    chk("t6_b_pop", 64'(o_valid), 64'd0);
`endif

    // Randomised back-to-back transfers across asynchronous clocks
    do_reset;
    got = 0;
    fork
      begin : sender
        for (int i = 0; i < 100; i++) begin
          int unsigned k;
          @(posedge sclk);
          data_async = 32'h1000_0000 + 32'(i);
          exp_q.push_back(data_async);
          @(posedge sclk);
          req_async = 1'b1;
          k = 0;
          while (ack !== 1'b1 && k < 400) begin
            @(posedge sclk);
            k++;
          end
          chk($sformatf("t3_w%0d_ack_hi", i), 64'(ack), 64'd1);
          req_async = 1'b0;
          k = 0;
          while (ack !== 1'b0 && k < 400) begin
            @(posedge sclk);
            k++;
          end
          chk($sformatf("t3_w%0d_ack_lo", i), 64'(ack), 64'd0);
        end
      end
      begin : consumer
        int unsigned cyc = 0;
        while (got < 100 && cyc < 30000) begin
          logic        pend;
          logic [31:0] d;
          i_ready = 1'($urandom_range(0, 1));
          pend    = o_valid & i_ready;
          d       = o_data;
          tick;
          cyc++;
          if (pend) begin
            if (exp_q.size() == 0) begin
              chk("t3_unexpected_word", 64'(d), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              chk($sformatf("t3_word%0d", got), 64'(d), 64'(exp_q.pop_front()));
            end
            got++;
          end
        end
        i_ready = 1'b0;
      end
    join
    chk("t3_count",   64'(got), 64'd100);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_perr",    64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
